// File: rtl/add_check_pkg.sv
// Shared definitions for the adder result checker: FSM state encoding,
// default sum width and the saturating counter increment.
package add_check_pkg;

   // Checker run phases; also exported on the top-level debug port.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WARMUP = 2'd1,
      CHECK  = 2'd2,
      DONE   = 2'd3
   } check_state_t;

   // Default operand width and the matching lossless sum width.
   localparam int WIDTH_DEFAULT = 4;
   localparam int SUM_W         = WIDTH_DEFAULT + 1;

   // Widest counter the saturating helper supports.
   localparam int MAX_CNT_W = 32;

   // Increment value, holding at the all-ones pattern of a cnt_w-bit counter.
   function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                    input int unsigned            cnt_w);
      logic [MAX_CNT_W-1:0] all_ones;
      if (cnt_w >= MAX_CNT_W) begin
         all_ones = '1;
      end else begin
         all_ones = (MAX_CNT_W'(1) << cnt_w) - MAX_CNT_W'(1);
      end
      if (value >= all_ones) begin
         return all_ones;
      end
      return value + MAX_CNT_W'(1);
   endfunction

endpackage

// File: rtl/add_result_checker_delay.sv
// sum_delay_line: DEPTH-stage shift register that lines the expected sum up
// with the adder output. It advances every cycle whatever the checker is
// doing, so expected values are already aligned when a run begins.
// DEPTH = 0 is a plain wire for combinational adders.
module sum_delay_line
   import add_check_pkg::*;
#(
   parameter int WIDTH = 5,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         // No storage: clock and reset are intentionally left unused.
         logic unused_clk_rst;
         assign unused_clk_rst = &{1'b0, clk, rst_n};
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Shift the expected sum one stage per clock; reset empties the line.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= '0;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/add_result_checker.sv
// add_result_checker: watches an adder's operands and sum, compares the sum
// against a + b delayed by the adder latency for a fixed window of samples
// and reports a registered pass/fail verdict with match/error counts.
//
// start protocol: start is a single-cycle pulse, sampled on the rising edge.
// It is acted on only in IDLE or DONE; while busy it is ignored. There is no
// backpressure: the checker compares one sample every CHECK cycle.
module add_result_checker
   import add_check_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int LATENCY     = 1,
   parameter int NUM_SAMPLES = 16,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH:0]   c,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH:0]   first_err,
   output check_state_t     dbg_state
);

   // Last warmup phase index; unused when the adder is combinational.
   localparam int WARM_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
   // Phase counter covers both the warmup length (<= 8) and the sample window.
   localparam int PH_W = CNT_W + 4;

   check_state_t    state;
   logic [PH_W-1:0] phase;

   logic [WIDTH:0]   sum_now;
   logic [WIDTH:0]   expected;
   logic             mismatch;
   logic             last_warm;
   logic             last_sample;
   logic [CNT_W-1:0] match_next;
   logic [CNT_W-1:0] err_next;

   // Lossless sum of the operands currently presented to the adder.
   assign sum_now = {1'b0, a} + {1'b0, b};

   sum_delay_line #(
      .WIDTH (WIDTH + 1),
      .DEPTH (LATENCY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sum_now),
      .dout  (expected)
   );

   assign mismatch    = (c != expected);
   assign last_warm   = (phase == PH_W'(WARM_LAST));
   assign last_sample = (phase == PH_W'(NUM_SAMPLES - 1));

   assign match_next = CNT_W'(sat_inc(MAX_CNT_W'(match_cnt), CNT_W));
   assign err_next   = CNT_W'(sat_inc(MAX_CNT_W'(err_cnt), CNT_W));

   assign dbg_state = state;

   // Run sequencer plus result registers: counts, first error and verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         match_cnt <= '0;
         err_cnt   <= '0;
         first_err <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  phase     <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  match_cnt <= '0;
                  err_cnt   <= '0;
                  first_err <= '0;
                  if (LATENCY == 0) begin
                     state <= CHECK;
                  end else begin
                     state <= WARMUP;
                  end
               end
            end

            WARMUP: begin
               // Let the first post-start operands travel through the adder.
               if (last_warm) begin
                  state <= CHECK;
                  phase <= '0;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            CHECK: begin
               if (mismatch) begin
                  err_cnt <= err_next;
                  if (err_cnt == '0) begin
                     first_err <= c;
                  end
               end else begin
                  match_cnt <= match_next;
               end

               if (last_sample) begin
                  // Verdict includes this final comparison.
                  state <= DONE;
                  phase <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == '0) && !mismatch;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               phase <= '0;
               busy  <= 1'b0;
               done  <= 1'b0;
               pass  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_result_checker.sv
// Bench for add_result_checker: three checker instances (latency 1,
// latency 0, narrow counters) fed by behavioural adders with fault injection.
// Expected verdicts are computed from the operand/fault tables and queued at
// start; a monitor pops and compares when a checker raises done.
module tb_add_result_checker;
   import add_check_pkg::*;

   localparam int W  = 4;
   localparam int SW = W + 1;
   localparam int EW = 56;  // {inst[2], done_cycle[16], pass, match[16], err[16], first_err[5]}

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- stimulus signals ----------------
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          flt_en = 1'b0;
   logic [SW-1:0] flt_val = '0;
   logic          start_l1 = 1'b0;
   logic          start_l0 = 1'b0;
   logic          start_c4 = 1'b0;

   // Behavioural adders: one registered, one combinational; a fault
   // replaces the sum of the operands it is driven alongside.
   logic [SW-1:0] c1 = '0;
   logic [SW-1:0] c0;
   always @(posedge clk) c1 <= flt_en ? flt_val : ({1'b0, a} + {1'b0, b});
   assign c0 = flt_en ? flt_val : ({1'b0, a} + {1'b0, b});

   // ---------------- DUTs ----------------
   logic          busy_l1, done_l1, pass_l1, busy_l0, done_l0, pass_l0, busy_c4, done_c4, pass_c4;
   logic [15:0]   match_l1, err_l1, match_l0, err_l0;
   logic [3:0]    match_c4, err_c4;
   logic [SW-1:0] ferr_l1, ferr_l0, ferr_c4;
   check_state_t  st_l1, st_l0, st_c4;

   add_result_checker #(.WIDTH(W), .LATENCY(1), .NUM_SAMPLES(16), .CNT_W(16)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .start(start_l1), .a(a), .b(b), .c(c1),
      .busy(busy_l1), .done(done_l1), .pass(pass_l1), .match_cnt(match_l1),
      .err_cnt(err_l1), .first_err(ferr_l1), .dbg_state(st_l1));

   add_result_checker #(.WIDTH(W), .LATENCY(0), .NUM_SAMPLES(16), .CNT_W(16)) u_dut_l0 (
      .clk(clk), .rst_n(rst_n), .start(start_l0), .a(a), .b(b), .c(c0),
      .busy(busy_l0), .done(done_l0), .pass(pass_l0), .match_cnt(match_l0),
      .err_cnt(err_l0), .first_err(ferr_l0), .dbg_state(st_l0));

   add_result_checker #(.WIDTH(W), .LATENCY(1), .NUM_SAMPLES(15), .CNT_W(4)) u_dut_c4 (
      .clk(clk), .rst_n(rst_n), .start(start_c4), .a(a), .b(b), .c(c1),
      .busy(busy_c4), .done(done_c4), .pass(pass_c4), .match_cnt(match_c4),
      .err_cnt(err_c4), .first_err(ferr_c4), .dbg_state(st_c4));

   // Uniform per-instance views for the monitor and driver.
   logic          busy_v [3];
   logic          done_v [3];
   logic          pass_v [3];
   logic [15:0]   mcnt_v [3];
   logic [15:0]   ecnt_v [3];
   logic [SW-1:0] ferr_v [3];
   check_state_t  st_v   [3];
   always_comb begin
      busy_v[0] = busy_l1;  done_v[0] = done_l1;  pass_v[0] = pass_l1;
      mcnt_v[0] = match_l1; ecnt_v[0] = err_l1;   ferr_v[0] = ferr_l1; st_v[0] = st_l1;
      busy_v[1] = busy_l0;  done_v[1] = done_l0;  pass_v[1] = pass_l0;
      mcnt_v[1] = match_l0; ecnt_v[1] = err_l0;   ferr_v[1] = ferr_l0; st_v[1] = st_l0;
      busy_v[2] = busy_c4;  done_v[2] = done_c4;  pass_v[2] = pass_c4;
      mcnt_v[2] = {12'd0, match_c4}; ecnt_v[2] = {12'd0, err_c4}; ferr_v[2] = ferr_c4; st_v[2] = st_c4;
   end

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Operand / fault tables, indexed by cycle after the start edge.
   logic [W-1:0]  op_a [64];
   logic [W-1:0]  op_b [64];
   logic          fl_en[64];
   logic [SW-1:0] fl_v [64];

   // Reference: sample i sees sum a_i+b_i unless faulted; counts saturate.
   function automatic logic [EW-1:0] predict(input int inst, input int ns, input int cnt_w,
                                             input int done_cyc);
      int m = 0;
      int e = 0;
      int fe = 0;
      int s, ci, cap;
      for (int i = 0; i < ns; i++) begin
         s  = int'(op_a[i]) + int'(op_b[i]);
         ci = fl_en[i] ? int'(fl_v[i]) : s;
         if (ci == s) begin
            m++;
         end else begin
            if (e == 0) fe = ci;
            e++;
         end
      end
      cap = (1 << cnt_w) - 1;
      if (m > cap) m = cap;
      if (e > cap) e = cap;
      return {2'(inst), 16'(done_cyc), (e == 0), 16'(m), 16'(e), 5'(fe)};
   endfunction

   // Monitor: verdict check on each rising done, pass-without-done check every cycle.
   logic done_d [3] = '{default: 1'b0};
   always @(negedge clk) begin
      logic [EW-1:0] e;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("pass_without_done[%0d]", k), 64'(pass_v[k] & ~done_v[k]), 64'd0);
         if (done_v[k] && !done_d[k]) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done[%0d]: actual done=1 required no verdict pending", k);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("done_inst[%0d]", k), 64'(k), 64'(e[55:54]));
               check($sformatf("done_cycle[%0d]", k), 64'(cyc), 64'(e[53:38]));
               check($sformatf("pass[%0d]", k), 64'(pass_v[k]), 64'(e[37]));
               check($sformatf("match_cnt[%0d]", k), 64'(mcnt_v[k]), 64'(e[36:21]));
               check($sformatf("err_cnt[%0d]", k), 64'(ecnt_v[k]), 64'(e[20:5]));
               check($sformatf("first_err[%0d]", k), 64'(ferr_v[k]), 64'(e[4:0]));
            end
         end
         done_d[k] <= done_v[k];
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_start(input int inst, input logic v);
      case (inst)
         0:       start_l1 = v;
         1:       start_l0 = v;
         default: start_c4 = v;
      endcase
   endtask

   task automatic check_reset_outputs(input int k, input string tag);
      check($sformatf("%s_busy[%0d]", tag, k), 64'(busy_v[k]), 64'd0);
      check($sformatf("%s_done[%0d]", tag, k), 64'(done_v[k]), 64'd0);
      check($sformatf("%s_pass[%0d]", tag, k), 64'(pass_v[k]), 64'd0);
      check($sformatf("%s_match[%0d]", tag, k), 64'(mcnt_v[k]), 64'd0);
      check($sformatf("%s_err[%0d]", tag, k), 64'(ecnt_v[k]), 64'd0);
      check($sformatf("%s_ferr[%0d]", tag, k), 64'(ferr_v[k]), 64'd0);
   endtask

   task automatic randomize_ops(input int fault_pct);
      for (int i = 0; i < 64; i++) begin
         op_a[i]  = W'($urandom_range(0, 15));
         op_b[i]  = W'($urandom_range(0, 15));
         fl_en[i] = ($urandom_range(0, 99) < fault_pct);
         fl_v[i]  = SW'($urandom_range(0, 31));
      end
   endtask

   // One run: start pulse, operands for every cycle, optional mid-run
   // start pulse or reset (cycle index relative to the start edge).
   task automatic run(input int inst, input int lat, input int ns, input int cnt_w,
                      input int restart_at, input int reset_at);
      int x;
      int budget;
      @(posedge clk); #1;
      set_start(inst, 1'b1);
      x = cyc;
      if (reset_at < 0) exp_q.push_back(predict(inst, ns, cnt_w, x + 1 + lat + ns));
      for (int j = 0; j < lat + ns + 2; j++) begin
         @(posedge clk); #1;
         set_start(inst, (j == restart_at));
         a       = op_a[j];
         b       = op_b[j];
         flt_en  = fl_en[j];
         flt_val = fl_v[j];
         if (j == 0) check($sformatf("busy_after_start[%0d]", inst), 64'(busy_v[inst]), 64'd1);
         if (j == reset_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs(inst, "midrun_reset");
            set_start(inst, 1'b0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
      end
      set_start(inst, 1'b0);
      budget = 0;
      while (exp_q.size() != 0 && budget < 30) begin
         @(posedge clk);
         budget++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL run_timeout[%0d]: actual %0d verdicts pending required 0", inst, exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      for (int i = 0; i < 64; i++) begin
         op_a[i] = '0; op_b[i] = '0; fl_en[i] = 1'b0; fl_v[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check_reset_outputs(k, "reset");
         check($sformatf("reset_state[%0d]", k), 64'(st_v[k]), 64'(IDLE));
      end
      rst_n = 1'b1;

      // Held 5+4 through a correct registered adder.
      for (int i = 0; i < 64; i++) begin op_a[i] = 4'd5; op_b[i] = 4'd4; fl_en[i] = 1'b0; end
      run(0, 1, 16, 16, -1, -1);

      // 15+15 = 30 with the adder returning 0 on sample 3 only.
      for (int i = 0; i < 64; i++) begin op_a[i] = 4'd15; op_b[i] = 4'd15; fl_en[i] = 1'b0; end
      fl_en[3] = 1'b1;
      fl_v[3]  = 5'd0;
      run(0, 1, 16, 16, -1, -1);

      // Combinational adder, ramping a, b = 1.
      for (int i = 0; i < 64; i++) begin op_a[i] = W'(i); op_b[i] = 4'd1; fl_en[i] = 1'b0; end
      run(1, 0, 16, 16, -1, -1);

      // start pulsed during CHECK cycle 5 must not restart the run.
      randomize_ops(0);
      run(0, 1, 16, 16, 1 + 5, -1);
      randomize_ops(20);
      run(1, 0, 16, 16, 5, -1);

      // Random operands with random faults on both latencies.
      for (int r = 0; r < 4; r++) begin
         randomize_ops(25);
         run(0, 1, 16, 16, -1, -1);
         randomize_ops(25);
         run(1, 0, 16, 16, -1, -1);
      end

      // Reset at CHECK cycle 8, then a clean full window.
      randomize_ops(30);
      run(0, 1, 16, 16, -1, 1 + 8);
      for (int i = 0; i < 64; i++) begin op_a[i] = 4'd5; op_b[i] = 4'd4; fl_en[i] = 1'b0; end
      run(0, 1, 16, 16, -1, -1);

      // Narrow counters: every sample wrong, then a correct rerun from DONE.
      randomize_ops(0);
      for (int i = 0; i < 64; i++) begin fl_en[i] = 1'b1; fl_v[i] = 5'd31; end
      run(2, 1, 15, 4, -1, -1);
      for (int i = 0; i < 64; i++) fl_en[i] = 1'b0;
      run(2, 1, 15, 4, -1, -1);

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL leftover_verdicts: actual %0d required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
